// File: rtl/split_search_pkg.sv
// Shared types and constants for the split-checker candidate search engine.
// Holds the FSM state encoding, xorshift64 parameters and sizing helpers.
package split_search_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [63:0] XS_DEFAULT_SEED = 64'h9E37_79B9_7F4A_7C15;
    localparam int          XS_SH_A         = 13;
    localparam int          XS_SH_B         = 7;
    localparam int          XS_SH_C         = 17;

    // Number of 64-bit generator words needed to cover a w-bit candidate.
    function automatic int nw(input int w);
        return (w + 63) / 64;
    endfunction

    function automatic logic [63:0] xs_next(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << XS_SH_A);
        t = t ^ (t >> XS_SH_B);
        t = t ^ (t << XS_SH_C);
        return t;
    endfunction

endpackage

// File: rtl/split_xorshift64.sv
// 64-bit xorshift generator state with seed load and one-step advance.
// A zero seed is swapped for the default so the sequence never sticks at zero.
module split_xorshift64
    import split_search_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [63:0] seed_i,
    input  logic        step_i,
    output logic [63:0] next_o
);

    logic [63:0] state_q;

    assign next_o = xs_next(state_q);

    // Generator state: reset, load (with zero substitution), step or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= XS_DEFAULT_SEED;
        end else if (load_i) begin
            state_q <= (seed_i == 64'd0) ? XS_DEFAULT_SEED : seed_i;
        end else if (step_i) begin
            state_q <= next_o;
        end else begin
            state_q <= state_q;
        end
    end

endmodule

// File: rtl/split_search.sv
// Candidate generator for a split_N constraint checker: fills, holds and
// evaluates pseudo-random assignments until satisfied, aborted or out of tries.
module split_search
    import split_search_pkg::*;
#(
    parameter int W       = 654,
    parameter int CHK_LAT = 0,
    parameter int TW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [63:0]   seed,
    input  logic [TW-1:0] max_tries,
    output logic [W-1:0]  assign_o,
    output logic          cand_valid,
    input  logic          chk_x_i,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          found,
    output logic [TW-1:0] tries
);

    localparam int NWORDS = nw(W);
    localparam int FCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int HCW    = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;

    state_e         state_q;
    logic [W-1:0]   cand_q;
    logic           cand_valid_q;
    logic           busy_q;
    logic           res_valid_q;
    logic           found_q;
    logic [TW-1:0]  tries_q;
    logic [FCW-1:0] fill_cnt_q;
    logic [HCW-1:0] hold_cnt_q;

    logic           xs_load_s;
    logic           xs_step_s;
    logic [63:0]    xs_next_s;
    logic [W+63:0]  cand_wide_s;
    logic [W-1:0]   cand_d;
    logic [TW-1:0]  tries_d;

    split_xorshift64 u_xs (
        .clk    (clk),
        .rst    (rst),
        .load_i (xs_load_s),
        .seed_i (seed),
        .step_i (xs_step_s),
        .next_o (xs_next_s)
    );

    // Generator control, next candidate word shift and saturating try count.
    always_comb begin
        xs_load_s   = (state_q == ST_IDLE) && start;
        xs_step_s   = (state_q == ST_FILL) && !abort;
        cand_wide_s = {cand_q, xs_next_s};
        cand_d      = cand_wide_s[W-1:0];
        if (tries_q == {TW{1'b1}}) begin
            tries_d = tries_q;
        end else begin
            tries_d = tries_q + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Search FSM with all host- and checker-facing outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cand_q       <= '0;
            cand_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            found_q      <= 1'b0;
            tries_q      <= '0;
            fill_cnt_q   <= '0;
            hold_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_FILL;
                        busy_q     <= 1'b1;
                        found_q    <= 1'b0;
                        tries_q    <= '0;
                        fill_cnt_q <= '0;
                    end
                end
                ST_FILL: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cand_q <= cand_d;
                        if (fill_cnt_q == FCW'(NWORDS - 1)) begin
                            state_q      <= ST_HOLD;
                            cand_valid_q <= 1'b1;
                            hold_cnt_q   <= '0;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + {{(FCW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        cand_valid_q <= 1'b0;
                    end else if (hold_cnt_q == HCW'(CHK_LAT)) begin
                        // Verdict is sampled only on the final hold cycle.
                        tries_q      <= tries_d;
                        cand_valid_q <= 1'b0;
                        if (chk_x_i) begin
                            state_q     <= ST_DONE;
                            found_q     <= 1'b1;
                            res_valid_q <= 1'b1;
                        end else if ((max_tries != '0) && (tries_d == max_tries)) begin
                            state_q     <= ST_DONE;
                            found_q     <= 1'b0;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q    <= ST_FILL;
                            fill_cnt_q <= '0;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + {{(HCW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (abort || res_ready) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    cand_valid_q <= 1'b0;
                    res_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign assign_o   = cand_q;
    assign cand_valid = cand_valid_q;
    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign found      = found_q;
    assign tries      = tries_q;

endmodule

// File: tb/tb_split_search.sv
// Scoreboard bench for split_search: stimulus queues expected results, a
// negedge monitor pops and compares them when res_valid rises.
module tb_split_search;

    localparam int          W   = 654;
    localparam logic [63:0] DEF = 64'h9E37_79B9_7F4A_7C15;

    typedef struct {
        logic          found;
        logic [31:0]   tries;
        logic [W-1:0]  cand;
        int            cycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          start0 = 1'b0, abort0 = 1'b0, rr0 = 1'b1, mode0 = 1'b0;
    logic [63:0]   seed0 = 64'd0;
    logic [31:0]   max0 = 32'd0;
    logic [W-1:0]  asg0;
    logic          cv0, busy0, rv0, found0;
    logic [31:0]   tries0;

    logic          start2 = 1'b0, rr2 = 1'b1;
    logic [63:0]   seed2 = 64'd0;
    logic [31:0]   max2 = 32'd0;
    logic [W-1:0]  asg2;
    logic          cv2, busy2, rv2, found2, chk2;
    logic [31:0]   tries2;
    logic [W-1:0]  third_cand = '0;

    int   cyc = 0, base0 = 0, base2 = 0;
    int   total = 0, bad = 0;
    int   cv_cyc0 = 0, cv_rise0 = 0, cv_cyc2 = 0, cv_rise2 = 0;
    exp_t q0[$];
    exp_t q2[$];

    assign chk2 = cv2 && (asg2 == third_cand);

    split_search #(.W(W), .CHK_LAT(0), .TW(32)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .seed(seed0),
        .max_tries(max0), .assign_o(asg0), .cand_valid(cv0), .chk_x_i(mode0),
        .busy(busy0), .res_valid(rv0), .res_ready(rr0), .found(found0), .tries(tries0)
    );

    split_search #(.W(W), .CHK_LAT(2), .TW(32)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .seed(seed2),
        .max_tries(max2), .assign_o(asg2), .cand_valid(cv2), .chk_x_i(chk2),
        .busy(busy2), .res_valid(rv2), .res_ready(rr2), .found(found2), .tries(tries2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] xs(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    // Candidate held after ntry full fills (11 words each) starting from seed.
    function automatic logic [W-1:0] cand_after(input logic [63:0] sd, input int ntry);
        logic [63:0]  s;
        logic [W-1:0] c;
        s = sd;
        c = '0;
        for (int i = 0; i < ntry * 11; i++) begin
            s = xs(s);
            c = {c[W-65:0], s};
        end
        return c;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: result scoreboard, cand_valid accounting and HOLD stability.
    initial begin
        logic         prv0, prv2, pcv2;
        logic [W-1:0] pasg2;
        exp_t         e;
        prv0 = 1'b0; prv2 = 1'b0; pcv2 = 1'b0; pasg2 = '0;
        forever begin
            @(negedge clk);
            if (cv0) cv_cyc0++;
            if (cv0 && !pcv_dummy(cv0)) begin end
            if (cv2) cv_cyc2++;
            if (cv2 && !pcv2) cv_rise2++;
            if (cv2 && pcv2) check("hold_stable2", asg2, pasg2);
            if (rv0 && !prv0) begin
                if (q0.size() == 0) begin
                    check("unexpected_result0", 1'b1, 1'b0);
                end else begin
                    e = q0.pop_front();
                    check("found0", found0, e.found);
                    check("tries0", tries0, e.tries);
                    check("cand0", asg0, e.cand);
                    check("latency0", cyc - base0, e.cycle);
                end
            end
            if (rv2 && !prv2) begin
                if (q2.size() == 0) begin
                    check("unexpected_result2", 1'b1, 1'b0);
                end else begin
                    e = q2.pop_front();
                    check("found2", found2, e.found);
                    check("tries2", tries2, e.tries);
                    check("cand2", asg2, e.cand);
                    check("latency2", cyc - base2, e.cycle);
                end
            end
            prv0 = rv0; prv2 = rv2; pcv2 = cv2; pasg2 = asg2;
        end
    end

    // Rising edges of cand_valid on dut0, tracked separately for clarity.
    initial begin
        logic p;
        p = 1'b0;
        forever begin
            @(negedge clk);
            if (cv0 && !p) cv_rise0++;
            p = cv0;
        end
    end

    function automatic logic pcv_dummy(input logic v);
        return v;
    endfunction

    task automatic go0(input logic [63:0] sd, input logic [31:0] mx, input logic md);
        seed0 = sd; max0 = mx; mode0 = md; start0 = 1'b1;
        base0 = cyc; cv_cyc0 = 0; cv_rise0 = 0;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_idle0(input int limit, input string nm);
        for (int i = 0; i < limit && busy0; i++) @(negedge clk);
        check(nm, busy0, 1'b0);
    endtask

    task automatic wait_cycle0(input int k);
        for (int i = 0; i < 200 && (cyc - base0) < k; i++) @(negedge clk);
    endtask

    task automatic check_reset0(input string nm);
        check({nm, "_assign"}, asg0, '0);
        check({nm, "_cv"}, cv0, 1'b0);
        check({nm, "_busy"}, busy0, 1'b0);
        check({nm, "_rv"}, rv0, 1'b0);
        check({nm, "_found"}, found0, 1'b0);
        check({nm, "_tries"}, tries0, 32'd0);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        check_reset0("reset");
        rst = 1'b0;
        @(negedge clk);

        // First-try hit from seed 1: result in cycle 13.
        e.found = 1'b1; e.tries = 32'd1; e.cand = cand_after(64'd1, 1); e.cycle = 13;
        q0.push_back(e);
        go0(64'd1, 32'd0, 1'b1);
        wait_idle0(40, "timeout_hit");
        check("first_word_top", asg0[W-1:W-14], 14'h2041);
        check("hit_cv_cycles", cv_cyc0, 1);

        // Never-satisfied checker with a budget of 5 tries.
        e.found = 1'b0; e.tries = 32'd5; e.cand = cand_after(64'h1234, 5); e.cycle = 61;
        q0.push_back(e);
        go0(64'h1234, 32'd5, 1'b0);
        wait_idle0(100, "timeout_budget");
        check("budget_cv_cycles", cv_cyc0, 5);
        check("budget_cv_pulses", cv_rise0, 5);

        // Zero seed runs the default-seed stream.
        e.found = 1'b1; e.tries = 32'd1; e.cand = cand_after(DEF, 1); e.cycle = 13;
        q0.push_back(e);
        go0(64'd0, 32'd0, 1'b1);
        wait_idle0(40, "timeout_seed0");

        // Host stalls in DONE; start during the stall must be ignored.
        e.found = 1'b1; e.tries = 32'd1; e.cand = cand_after(64'd77, 1); e.cycle = 13;
        q0.push_back(e);
        rr0 = 1'b0;
        go0(64'd77, 32'd0, 1'b1);
        for (int i = 0; i < 40 && !rv0; i++) @(negedge clk);
        check("stall_reached", rv0, 1'b1);
        start0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_rv", rv0, 1'b1);
            check("stall_found", found0, 1'b1);
            check("stall_tries", tries0, 32'd1);
            check("stall_busy", busy0, 1'b1);
        end
        start0 = 1'b0; rr0 = 1'b1;
        @(negedge clk);
        check("release_rv", rv0, 1'b0);
        check("release_busy", busy0, 1'b0);

        // Third-candidate detector on the CHK_LAT=2 instance.
        third_cand = cand_after(64'd5, 3);
        e.found = 1'b1; e.tries = 32'd3; e.cand = third_cand; e.cycle = 43;
        q2.push_back(e);
        seed2 = 64'd5; max2 = 32'd0; start2 = 1'b1; base2 = cyc; cv_cyc2 = 0; cv_rise2 = 0;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 80 && busy2; i++) @(negedge clk);
        check("timeout_lat2", busy2, 1'b0);
        check("lat2_cv_cycles", cv_cyc2, 9);
        check("lat2_cv_pulses", cv_rise2, 3);

        // Abort in FILL cycle 4.
        go0(64'd9, 32'd0, 1'b0);
        wait_cycle0(4);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        check("abort_fill_busy", busy0, 1'b0);
        check("abort_fill_rv", rv0, 1'b0);
        check("abort_fill_tries", tries0, 32'd0);
        check("abort_fill_found", found0, 1'b0);
        repeat (20) @(negedge clk);

        // Abort on the sampling cycle of try 2 wins over the sample.
        go0(64'd9, 32'd0, 1'b0);
        wait_cycle0(24);
        check("abort_hold_cv", cv0, 1'b1);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        check("abort_hold_busy", busy0, 1'b0);
        check("abort_hold_cv_off", cv0, 1'b0);
        check("abort_hold_tries", tries0, 32'd1);
        repeat (20) @(negedge clk);

        // Reset during HOLD.
        go0(64'd3, 32'd0, 1'b0);
        wait_cycle0(24);
        check("rst_hold_cv", cv0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset0("midrst");
        repeat (20) @(negedge clk);

        check("q0_drained", q0.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
